// File: rtl/p_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package p_hazard_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MD_BUSY = 2'd2
  } hz_state_t;

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam int          DEF_CNT_W   = 16;

endpackage

// File: rtl/p_sat_counter.sv
// Free-running up counter that sticks at all-ones instead of wrapping.
module p_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/p_hazard_ctrl.sv
// Front-end control: redirects on taken branches, one-cycle load-use stalls,
// and front-end hold while a multi-cycle mul/div is in flight.
module p_hazard_ctrl
  import p_hazard_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_uses_rs1,
  input  logic              i_id_uses_rs2,
  input  logic              i_ex_valid,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_branch_taken,
  input  logic [WIDTH-1:0]  i_ex_target,
  input  logic              i_ex_md_start,
  input  logic              i_md_done,
  output logic              o_pc_sel,
  output logic [WIDTH-1:0]  o_jump_target,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic              o_ex_hold,
  output logic [CNT_W-1:0]  o_stall_cycles,
  output logic [CNT_W-1:0]  o_redirects
);

  hz_state_t state, state_next;
  logic      redirect, load_use, md_go;
  logic      stall_inc, redir_inc;

  always_comb begin
    redirect = i_ex_valid & i_ex_branch_taken;
    load_use = i_ex_valid & i_ex_mem_read & (i_ex_rd != '0) &
               ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));
    md_go    = i_ex_valid & i_ex_md_start & ~i_md_done;
  end

  // Priority within RUN: redirect beats load-use beats mul/div start.
  always_comb begin
    o_pc_sel      = 1'b0;
    o_jump_target = '0;
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_hold     = 1'b0;
    state_next    = state;
    stall_inc     = 1'b0;
    redir_inc     = 1'b0;
    case (state)
      BOOT: begin
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
        state_next    = RUN;
      end
      RUN: begin
        if (redirect) begin
          o_pc_sel      = 1'b1;
          o_jump_target = i_ex_target;
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
          redir_inc     = 1'b1;
        end else if (load_use) begin
          o_pc_en       = 1'b0;
          o_if_id_en    = 1'b0;
          o_id_ex_flush = 1'b1;
          stall_inc     = 1'b1;
        end else if (md_go) begin
          state_next    = MD_BUSY;
        end
      end
      MD_BUSY: begin
        o_pc_en    = 1'b0;
        o_if_id_en = 1'b0;
        o_ex_hold  = 1'b1;
        stall_inc  = 1'b1;
        if (i_md_done)
          state_next = RUN;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
    // Reset overrides everything so the front end sees a clean flush.
    if (rst) begin
      o_pc_sel      = 1'b0;
      o_jump_target = '0;
      o_pc_en       = 1'b1;
      o_if_id_en    = 1'b1;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      o_ex_hold     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= BOOT;
    else
      state <= state_next;
  end

  p_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .q   (o_stall_cycles)
  );

  p_sat_counter #(.WIDTH(CNT_W)) u_redir_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redir_inc),
    .q   (o_redirects)
  );

endmodule

// File: tb/tb_p_hazard_ctrl.sv
// Scoreboard bench for p_hazard_ctrl: a behavioural model pushes expected
// outputs per cycle, and a negedge checker pops and compares them.
module tb_p_hazard_ctrl;

  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  localparam logic [1:0] M_BOOT = 2'd0;
  localparam logic [1:0] M_RUN  = 2'd1;
  localparam logic [1:0] M_BUSY = 2'd2;

  typedef struct {
    logic              pc_sel;
    logic [WIDTH-1:0]  jump_target;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_hold;
    logic [CNT_W-1:0]  stall;
    logic [CNT_W-1:0]  redir;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              uses_rs1, uses_rs2, ex_valid, mem_read, br_taken;
  logic              md_start, md_done;
  logic [WIDTH-1:0]  ex_target;

  logic              pc_sel, pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold;
  logic [WIDTH-1:0]  jump_target;
  logic [CNT_W-1:0]  stall_cycles, redirects;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [1:0] m_state = M_BOOT;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_redir = '0;

  always #5 clk = ~clk;

  p_hazard_ctrl #(.WIDTH(WIDTH), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_id_rs1          (id_rs1),
    .i_id_rs2          (id_rs2),
    .i_id_uses_rs1     (uses_rs1),
    .i_id_uses_rs2     (uses_rs2),
    .i_ex_valid        (ex_valid),
    .i_ex_rd           (ex_rd),
    .i_ex_mem_read     (mem_read),
    .i_ex_branch_taken (br_taken),
    .i_ex_target       (ex_target),
    .i_ex_md_start     (md_start),
    .i_md_done         (md_done),
    .o_pc_sel          (pc_sel),
    .o_jump_target     (jump_target),
    .o_pc_en           (pc_en),
    .o_if_id_en        (if_id_en),
    .o_if_id_flush     (if_id_flush),
    .o_id_ex_flush     (id_ex_flush),
    .o_ex_hold         (ex_hold),
    .o_stall_cycles    (stall_cycles),
    .o_redirects       (redirects)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("pc_sel",      32'(pc_sel),       32'(e.pc_sel));
      checkOutput("jump_target", jump_target,       e.jump_target);
      checkOutput("pc_en",       32'(pc_en),        32'(e.pc_en));
      checkOutput("if_id_en",    32'(if_id_en),     32'(e.if_id_en));
      checkOutput("if_id_flush", 32'(if_id_flush),  32'(e.if_id_flush));
      checkOutput("id_ex_flush", 32'(id_ex_flush),  32'(e.id_ex_flush));
      checkOutput("ex_hold",     32'(ex_hold),      32'(e.ex_hold));
      checkOutput("stall_cycles", 32'(stall_cycles), 32'(e.stall));
      checkOutput("redirects",   32'(redirects),    32'(e.redir));
    end
  end

  task automatic clearInputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; ex_valid = 1'b0; mem_read = 1'b0;
    br_taken = 1'b0; md_start = 1'b0; md_done = 1'b0; ex_target = '0;
  endtask

  // One clock cycle: predict outputs from the current inputs, queue them,
  // then advance the model across the edge.
  task automatic applyStimulus(input bit do_check);
    exp_t e;
    bit   redir, lu, go;
    redir = ex_valid & br_taken;
    lu    = ex_valid & mem_read & (ex_rd != 0) &
            ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));
    go    = ex_valid & md_start & ~md_done;
    e.pc_sel = 1'b0; e.jump_target = '0; e.pc_en = 1'b1; e.if_id_en = 1'b1;
    e.if_id_flush = 1'b0; e.id_ex_flush = 1'b0; e.ex_hold = 1'b0;
    e.stall = m_stall; e.redir = m_redir;
    if (rst) begin
      e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
    end else if (m_state == M_BOOT) begin
      e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
    end else if (m_state == M_BUSY) begin
      e.pc_en = 1'b0; e.if_id_en = 1'b0; e.ex_hold = 1'b1;
    end else if (redir) begin
      e.pc_sel = 1'b1; e.jump_target = ex_target;
      e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
    end else if (lu) begin
      e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_ex_flush = 1'b1;
    end
    if (do_check) exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_state = M_BOOT; m_stall = '0; m_redir = '0;
    end else begin
      case (m_state)
        M_BOOT: m_state = M_RUN;
        M_BUSY: begin
          if (m_stall != 16'hFFFF) m_stall = m_stall + 1'b1;
          if (md_done) m_state = M_RUN;
        end
        default: begin
          if (redir) begin
            if (m_redir != 16'hFFFF) m_redir = m_redir + 1'b1;
          end else if (lu) begin
            if (m_stall != 16'hFFFF) m_stall = m_stall + 1'b1;
          end else if (go) begin
            m_state = M_BUSY;
          end
        end
      endcase
    end
    #1;
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset release: first reset cycle has undefined counters, so skip it.
    applyStimulus(0);
    applyStimulus(1);
    rst = 1'b0;
    applyStimulus(1);
    applyStimulus(1);
    applyStimulus(1);

    // Taken branch.
    ex_valid = 1'b1; br_taken = 1'b1; ex_target = 32'h0000_0040;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);

    // Load-use on rs2, then rd=0, then matching but unused rs1.
    ex_valid = 1'b1; mem_read = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd3; uses_rs1 = 1'b1; id_rs2 = 5'd5; uses_rs2 = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    ex_valid = 1'b1; mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; uses_rs2 = 1'b1;
    applyStimulus(1);
    clearInputs();
    ex_valid = 1'b1; mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; uses_rs1 = 1'b0;
    applyStimulus(1);
    clearInputs();
    ex_valid = 1'b1; mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; uses_rs1 = 1'b1;
    applyStimulus(1);
    clearInputs();

    // Branch and load-use together: redirect wins.
    ex_valid = 1'b1; br_taken = 1'b1; ex_target = 32'h0000_1234;
    mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; uses_rs1 = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);

    // Stray done in RUN is ignored.
    md_done = 1'b1;
    applyStimulus(1);
    clearInputs();

    // Mul/div with done on the fourth busy cycle; a branch while busy is ignored.
    ex_valid = 1'b1; md_start = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    ex_valid = 1'b1; br_taken = 1'b1; ex_target = 32'hDEAD_BEE0;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    md_done = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);

    // Single-cycle mul/div: start and done together.
    ex_valid = 1'b1; md_start = 1'b1; md_done = 1'b1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);

    // Drive the stall counter into saturation while busy.
    ex_valid = 1'b1; md_start = 1'b1;
    applyStimulus(1);
    clearInputs();
    for (int i = 0; i < 65540; i++) applyStimulus(0);
    applyStimulus(1);
    checkOutput("stall_saturated", 32'(stall_cycles), 32'h0000_FFFF);

    // Reset while busy aborts to BOOT with counters cleared.
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    applyStimulus(1);
    applyStimulus(1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
